// File: rtl/prbs5_checker.sv
// prbs5_checker: self-synchronising receive monitor for the x^5+x^3+1 serial pattern.
// Hunts for LOCK_CNT consecutive predicted bits, then flags, counts and windows bit errors.
module prbs5_checker #(
  parameter int LOCK_CNT    = 8,
  parameter int LOSS_THRESH = 4,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             din,
  input  logic             err_clr,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_HUNT   = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  localparam logic [7:0]       LOCK_TGT = 8'(LOCK_CNT);
  localparam logic [5:0]       LOSS_TGT = 6'(LOSS_THRESH);
  localparam logic [4:0]       WIN_LAST = 5'd30;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_ALL  = {CNT_W{1'b1}};

  state_t           state_r, state_s;
  logic [4:0]       hist_r, hist_s;
  logic [2:0]       fill_cnt_r, fill_cnt_s;
  logic [7:0]       match_cnt_r, match_cnt_s;
  logic [4:0]       win_cnt_r, win_cnt_s;
  logic [5:0]       win_err_r, win_err_s;
  logic             locked_r, locked_s;
  logic             err_r, err_s;
  logic [CNT_W-1:0] err_cnt_r, err_cnt_s;
  logic             good_s;
  logic [7:0]       match_inc_s;
  logic [5:0]       win_err_inc_s;

  function automatic logic lfsr_pred(input logic tap2, input logic tap5);
    return tap2 ^ tap5;
  endfunction

  // Next-state, counter and output logic; nothing but the err pulse moves without en.
  always_comb begin
    state_s       = state_r;
    hist_s        = hist_r;
    fill_cnt_s    = fill_cnt_r;
    match_cnt_s   = match_cnt_r;
    win_cnt_s     = win_cnt_r;
    win_err_s     = win_err_r;
    locked_s      = locked_r;
    err_s         = 1'b0;
    err_cnt_s     = err_cnt_r;
    good_s        = (hist_r != 5'd0) && (din == lfsr_pred(hist_r[1], hist_r[4]));
    match_inc_s   = good_s ? (match_cnt_r + 8'd1) : 8'd0;
    // The bad bit on the wrap edge is the first one of the new window.
    win_err_inc_s = ((win_cnt_r == WIN_LAST) ? 6'd0 : win_err_r) + (good_s ? 6'd0 : 6'd1);
    if (en) begin
      hist_s = {hist_r[3:0], din};
      case (state_r)
        ST_FILL: begin
          if (fill_cnt_r == 3'd4) begin
            state_s     = ST_HUNT;
            fill_cnt_s  = 3'd0;
            match_cnt_s = 8'd0;
          end else begin
            fill_cnt_s  = fill_cnt_r + 3'd1;
          end
        end
        ST_HUNT: begin
          if (match_inc_s == LOCK_TGT) begin
            state_s     = ST_LOCKED;
            locked_s    = 1'b1;
            match_cnt_s = 8'd0;
            win_cnt_s   = 5'd0;
            win_err_s   = 6'd0;
          end else begin
            match_cnt_s = match_inc_s;
          end
        end
        ST_LOCKED: begin
          err_s     = ~good_s;
          win_cnt_s = (win_cnt_r == WIN_LAST) ? 5'd0 : (win_cnt_r + 5'd1);
          win_err_s = win_err_inc_s;
          if (win_err_inc_s >= LOSS_TGT) begin
            state_s     = ST_HUNT;
            locked_s    = 1'b0;
            match_cnt_s = 8'd0;
          end else begin
            locked_s    = 1'b1;
          end
        end
        default: begin
          state_s    = ST_FILL;
          locked_s   = 1'b0;
          fill_cnt_s = 3'd0;
        end
      endcase
      if (err_clr) begin
        err_cnt_s = {CNT_W{1'b0}};
      end else if (err_s && (err_cnt_r != CNT_ALL)) begin
        err_cnt_s = err_cnt_r + CNT_ONE;
      end else begin
        err_cnt_s = err_cnt_r;
      end
    end else begin
      err_s = 1'b0;
    end
  end

  // State, counter and output registers, cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_FILL;
      hist_r      <= 5'd0;
      fill_cnt_r  <= 3'd0;
      match_cnt_r <= 8'd0;
      win_cnt_r   <= 5'd0;
      win_err_r   <= 6'd0;
      locked_r    <= 1'b0;
      err_r       <= 1'b0;
      err_cnt_r   <= {CNT_W{1'b0}};
    end else begin
      state_r     <= state_s;
      hist_r      <= hist_s;
      fill_cnt_r  <= fill_cnt_s;
      match_cnt_r <= match_cnt_s;
      win_cnt_r   <= win_cnt_s;
      win_err_r   <= win_err_s;
      locked_r    <= locked_s;
      err_r       <= err_s;
      err_cnt_r   <= err_cnt_s;
    end
  end

  assign locked  = locked_r;
  assign err     = err_r;
  assign err_cnt = err_cnt_r;

endmodule
